oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
- CPU-side initiator for sprite OAM DMA ($4014); it drives the PPU register port, which is the opposite end from the PPU register responder.
- A CPU write to $4014 latches a source page, stalls the CPU, and copies 256 bytes from CPU address space ($XX00–$XXFF) into PPU OAMDATA ($2004).
- Each byte is one bus read followed by one bus write.
- Sits between the CPU core, the CPU bus mux and the PPU register decoder.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer
- OAM_DATA_ADDR, 16'h2004, destination address driven on every write cycle
- TRANSFER_COUNT, 256, bytes per transfer

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- clkEn  input  1  CPU-cycle enable; all state advances only when high
- cpuAddr_IN  input  16  CPU address bus (snooped)
- cpuReadWrite_IN  input  1  CPU direction, 1=read 0=write
- cpuData_IN  input  8  CPU write data (snooped, page latch)
- busData_IN  input  8  read data returned by bus for DMA reads
- cpuStall  output  1  1 = CPU halted (RDY low); bus owned by DMA
- dmaAddr_OUT  output  16  bus address while cpuStall=1
- dmaReadWrite  output  1  bus direction while stalled, 1=read 0=write
- dmaData_OUT  output  8  byte driven on DMA write cycles
- oamData_EN  output  1  PPU OAMDATA select, asserted only on write cycles
- busy  output  1  transfer in progress (trigger latched or stall active)

Behaviour:
- Reset values: cpuStall=0, dmaAddr_OUT=0, dmaReadWrite=1, dmaData_OUT=0, oamData_EN=0, busy=0.
- Reset also sets state=IDLE, byte counter=0, page=0, cycleParity=0.
- Reset has priority over clkEn and takes effect mid-transfer: outputs return to reset values on the next clk edge, and the partial transfer is abandoned.
- cycleParity toggles on every clkEn (0=get, 1=put), including while IDLE.
- All registered outputs change only on clk edges with clkEn=1. With clkEn=0, everything holds.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE: on clkEn with cpuReadWrite_IN=0 and cpuAddr_IN==DMA_REG_ADDR:
  - page <= cpuData_IN
  - busy <= 1
  - -> HALT
- HALT (one cycle; cpuStall=1, dmaReadWrite=1, bus idle):
  - next cycle is get -> READ
  - next cycle is put -> ALIGN
- ALIGN (one dummy read cycle): -> READ.
- READ (get cycles only):
  - dmaAddr_OUT={page, counter}, dmaReadWrite=1, oamData_EN=0
  - busData_IN captured into dmaData_OUT at the end of the cycle (clkEn edge)
  - -> WRITE
- WRITE (put cycles only):
  - dmaAddr_OUT=OAM_DATA_ADDR, dmaReadWrite=0, oamData_EN=1 for exactly this one clkEn period; dmaData_OUT stable throughout
  - counter <= counter+1
  - counter was 255 -> IDLE with cpuStall=0, busy=0, oamData_EN=0 on the following cycle; otherwise -> READ
- oamData_EN drops between every pair of writes. The PPU increments its OAM address on that falling edge, so there must never be back-to-back assertion.
- Counter is 8 bits and wraps 255->0 at completion. Source addresses never cross the page; the high byte never increments.
- Stall length: 513 CPU cycles if the trigger write lands so HALT is a put cycle, 514 otherwise.
- Triggers seen while busy=1 are ignored; the page latch is unchanged.
- CPU bus snooping is ignored while cpuStall=1.
- Reads of DMA_REG_ADDR have no effect.
- Register file write back-pressure is not supported; the PPU must accept a write every put cycle.

Decomposition:
- Shared package (nes_bus_pkg): state enum (IDLE, HALT, ALIGN, READ, WRITE), address constants DMA_REG_ADDR and OAM_DATA_ADDR, and get/put parity encoding. Reused by the APU/DMC DMA.
- No sub-module; single FSM plus counter, roughly 150 lines.

Test Plan:
- Write $4014=$02 with HALT landing on put -> cpuStall high 513 cycles; reads $0200..$02FF in order; 256 oamData_EN pulses each followed by a low cycle; dmaData_OUT matches the preloaded memory pattern.
- Same trigger shifted one cycle -> one ALIGN cycle; cpuStall high 514 cycles; byte sequence identical.
- Write $4013=$02 and read $4014 -> no stall, busy stays 0, no oamData_EN.
- Second $4014=$07 write issued during transfer (bus forced) -> ignored; all addresses stay in $02xx; exactly 256 writes.
- Assert reset after byte 100 is written -> next edge cpuStall=0, oamData_EN=0, busy=0. A fresh $4014=$03 then completes a full 256-byte transfer from $0300.
- clkEn pulsed 1-in-3 -> same address/data/oamData_EN sequence and cycle count measured in clkEn cycles; outputs never change on clkEn=0 edges.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions for the sprite OAM DMA and the APU/DMC DMA.
// Holds the DMA state encoding, fixed register addresses and get/put cycle parity.
package nes_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dmaState_t;

   localparam logic [15:0] DMA_REG_ADDR   = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR  = 16'h2004;
   localparam int          TRANSFER_COUNT = 256;
   localparam logic [7:0]  LAST_BYTE      = 8'(TRANSFER_COUNT - 1);

   // A CPU cycle is either a get (bus read slot) or a put (bus write slot).
   localparam logic PARITY_GET = 1'b0;
   localparam logic PARITY_PUT = 1'b1;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite OAM DMA initiator: a write to $4014 stalls the CPU and copies one
// 256-byte page of CPU space into PPU OAMDATA, one read plus one write per byte.
module oam_dma_controller
   import nes_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clkEn,
   input  logic [15:0] cpuAddr_IN,
   input  logic        cpuReadWrite_IN,
   input  logic [7:0]  cpuData_IN,
   input  logic [7:0]  busData_IN,
   output logic        cpuStall,
   output logic [15:0] dmaAddr_OUT,
   output logic        dmaReadWrite,
   output logic [7:0]  dmaData_OUT,
   output logic        oamData_EN,
   output logic        busy
);

   dmaState_t  state;
   dmaState_t  nextState;
   logic [7:0] page;
   logic [7:0] byteCount;
   logic [7:0] dataReg;
   logic       cycleParity;
   logic       trigger;

   // Snooping only matters in IDLE; while stalled the CPU is not driving the bus.
   assign trigger = !cpuReadWrite_IN && (cpuAddr_IN == DMA_REG_ADDR);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         page        <= '0;
         byteCount   <= '0;
         dataReg     <= '0;
         cycleParity <= PARITY_GET;
      end else if (clkEn) begin
         state       <= nextState;
         cycleParity <= ~cycleParity;
         if (state == IDLE && trigger)
            page <= cpuData_IN;
         if (state == READ)
            dataReg <= busData_IN;
         if (state == WRITE)
            byteCount <= byteCount + 8'd1;
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (trigger) nextState = HALT;
         // cycleParity is the parity of the HALT cycle itself; a put HALT
         // means the following cycle is already a get.
         HALT:    nextState = (cycleParity == PARITY_PUT) ? READ : ALIGN;
         ALIGN:   nextState = READ;
         READ:    nextState = WRITE;
         WRITE:   nextState = (byteCount == LAST_BYTE) ? IDLE : READ;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      cpuStall     = 1'b0;
      dmaAddr_OUT  = '0;
      dmaReadWrite = 1'b1;
      oamData_EN   = 1'b0;
      case (state)
         HALT: begin
            cpuStall = 1'b1;
         end
         ALIGN, READ: begin
            cpuStall    = 1'b1;
            dmaAddr_OUT = {page, byteCount};
         end
         WRITE: begin
            cpuStall     = 1'b1;
            dmaAddr_OUT  = OAM_DATA_ADDR;
            dmaReadWrite = 1'b0;
            oamData_EN   = 1'b1;
         end
         default: ;
      endcase
   end

   assign dmaData_OUT = dataReg;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: aligned/unaligned transfers, ignored
// register accesses, retrigger during transfer, mid-transfer reset, gated clkEn.
module tb_oam_dma_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        clkEn;
   logic [15:0] cpuAddr_IN;
   logic        cpuReadWrite_IN;
   logic [7:0]  cpuData_IN;
   logic [7:0]  busData_IN;
   logic        cpuStall;
   logic [15:0] dmaAddr_OUT;
   logic        dmaReadWrite;
   logic [7:0]  dmaData_OUT;
   logic        oamData_EN;
   logic        busy;
   logic [27:0] outs;

   int total = 0;
   int bad   = 0;
   bit gated = 1'b0;
   bit tbParity = 1'b0;

   oam_dma_controller dut (
      .clk             (clk),
      .reset           (reset),
      .clkEn           (clkEn),
      .cpuAddr_IN      (cpuAddr_IN),
      .cpuReadWrite_IN (cpuReadWrite_IN),
      .cpuData_IN      (cpuData_IN),
      .busData_IN      (busData_IN),
      .cpuStall        (cpuStall),
      .dmaAddr_OUT     (dmaAddr_OUT),
      .dmaReadWrite    (dmaReadWrite),
      .dmaData_OUT     (dmaData_OUT),
      .oamData_EN      (oamData_EN),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // Preloaded CPU memory image, returned for whatever address the DMA drives.
   function automatic logic [7:0] memByte(input logic [15:0] a);
      logic [7:0] lo;
      logic [7:0] hi;
      lo = a[7:0] ^ 8'h5A;
      hi = a[15:8] * 8'd3;
      return lo + hi;
   endfunction

   assign busData_IN = memByte(dmaAddr_OUT);
   assign outs = {cpuStall, dmaAddr_OUT, dmaReadWrite, dmaData_OUT, oamData_EN, busy};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One CPU cycle; in gated mode two dead clk edges precede the enabled one.
   task automatic tick();
      logic [27:0] snap;
      if (gated) begin
         clkEn = 1'b0;
         repeat (2) begin
            snap = outs;
            @(posedge clk);
            #1;
            check("hold", 32'(outs), 32'(snap));
         end
      end
      clkEn = 1'b1;
      @(posedge clk);
      #1;
      tbParity = ~tbParity;
      if (gated) clkEn = 1'b0;
   endtask

   task automatic cpuIdle();
      cpuAddr_IN      = 16'h0000;
      cpuReadWrite_IN = 1'b1;
      cpuData_IN      = 8'h00;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      tbParity = 1'b0;
   endtask

   task automatic checkIdleOutputs(input string tag);
      check({tag, ":stall"}, 32'(cpuStall), 32'd0);
      check({tag, ":addr"},  32'(dmaAddr_OUT), 32'd0);
      check({tag, ":rw"},    32'(dmaReadWrite), 32'd1);
      check({tag, ":oam"},   32'(oamData_EN), 32'd0);
      check({tag, ":busy"},  32'(busy), 32'd0);
   endtask

   // withAlign selects a trigger landing so HALT is a get cycle (dummy ALIGN read).
   task automatic runTransfer(input logic [7:0] pg, input bit withAlign,
                              input bit interfere, input int abortAfter, input string tag);
      int stallCnt;
      logic [15:0] src;
      stallCnt = 0;
      if (tbParity != withAlign) tick();
      cpuAddr_IN      = 16'h4014;
      cpuReadWrite_IN = 1'b0;
      cpuData_IN      = pg;
      tick();
      if (interfere) cpuData_IN = 8'h07;
      else cpuIdle();
      check({tag, ":haltStall"}, 32'(cpuStall), 32'd1);
      check({tag, ":haltBusy"},  32'(busy), 32'd1);
      check({tag, ":haltRw"},    32'(dmaReadWrite), 32'd1);
      check({tag, ":haltOam"},   32'(oamData_EN), 32'd0);
      stallCnt += int'(cpuStall);
      if (withAlign) begin
         tick();
         check({tag, ":alignStall"}, 32'(cpuStall), 32'd1);
         check({tag, ":alignRw"},    32'(dmaReadWrite), 32'd1);
         check({tag, ":alignOam"},   32'(oamData_EN), 32'd0);
         stallCnt += int'(cpuStall);
      end
      for (int b = 0; b < 256; b++) begin
         src = {pg, 8'(b)};
         tick();
         check({tag, ":rdAddr"}, 32'(dmaAddr_OUT), 32'(src));
         check({tag, ":rdRw"},   32'(dmaReadWrite), 32'd1);
         check({tag, ":rdOam"},  32'(oamData_EN), 32'd0);
         stallCnt += int'(cpuStall);
         tick();
         check({tag, ":wrAddr"}, 32'(dmaAddr_OUT), 32'h2004);
         check({tag, ":wrRw"},   32'(dmaReadWrite), 32'd0);
         check({tag, ":wrOam"},  32'(oamData_EN), 32'd1);
         check({tag, ":wrData"}, 32'(dmaData_OUT), 32'(memByte(src)));
         stallCnt += int'(cpuStall);
         if (b == abortAfter) begin
            applyReset();
            cpuIdle();
            checkIdleOutputs({tag, ":abort"});
            check({tag, ":abortData"}, 32'(dmaData_OUT), 32'd0);
            return;
         end
         if (b == 255) cpuIdle();
      end
      tick();
      check({tag, ":endStall"}, 32'(cpuStall), 32'd0);
      check({tag, ":endBusy"},  32'(busy), 32'd0);
      check({tag, ":endOam"},   32'(oamData_EN), 32'd0);
      check({tag, ":stallLen"}, 32'(stallCnt), withAlign ? 32'd514 : 32'd513);
   endtask

   initial begin
      reset = 1'b1;
      clkEn = 1'b1;
      cpuIdle();
      applyReset();
      checkIdleOutputs("reset");
      check("reset:data", 32'(dmaData_OUT), 32'd0);

      runTransfer(8'h02, 1'b0, 1'b0, -1, "aligned");
      runTransfer(8'h02, 1'b1, 1'b0, -1, "unaligned");

      cpuAddr_IN      = 16'h4013;
      cpuReadWrite_IN = 1'b0;
      cpuData_IN      = 8'h02;
      tick();
      check("wr4013:stall", 32'(cpuStall), 32'd0);
      check("wr4013:busy",  32'(busy), 32'd0);
      cpuAddr_IN      = 16'h4014;
      cpuReadWrite_IN = 1'b1;
      tick();
      check("rd4014:stall", 32'(cpuStall), 32'd0);
      check("rd4014:busy",  32'(busy), 32'd0);
      cpuIdle();
      tick();
      check("rd4014:oam",   32'(oamData_EN), 32'd0);
      check("rd4014:busy2", 32'(busy), 32'd0);

      runTransfer(8'h02, 1'b0, 1'b1, -1, "retrigger");
      tick();
      check("retrigger:after", 32'(busy), 32'd0);

      runTransfer(8'h02, 1'b0, 1'b0, 100, "abort");
      runTransfer(8'h03, 1'b0, 1'b0, -1, "restart");

      gated = 1'b1;
      runTransfer(8'h05, 1'b0, 1'b0, -1, "gated");
      gated = 1'b0;
      clkEn = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
